// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encoding, register-select
// encodings and the default address width.
package lsu_pkg;

  localparam int LSU_ADDR_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_MEM     = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } lsu_state_e;

  typedef enum logic [1:0] {
    REG_X    = 2'b00,
    REG_Y    = 2'b01,
    REG_ACC  = 2'b10,
    REG_RSVD = 2'b11
  } lsu_reg_e;

  function automatic logic is_rsvd_reg(input logic [1:0] sel);
    return (sel == REG_RSVD);
  endfunction

endpackage

// File: rtl/lsu_timeout_counter.sv
// Counts consecutive enabled cycles; expired is high in the TIMEOUT-th enabled
// cycle. Only instantiated when LSU_TIMEOUT_EN is defined.
module lsu_timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_count;

  assign o_expired = i_enable && (r_count == CNT_W'(TIMEOUT - 1));

  // Saturates at the expiry value so a stalled enable cannot wrap around.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-command load/store unit between a register file and a memory port.
// Optional feature: define LSU_TIMEOUT_EN to abort a stalled memory access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = LSU_ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_store,
  input  logic [1:0]        cmd_reg,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              reg_read_x,
  output logic              reg_read_y,
  input  logic [15:0]       reg_data,
  input  logic [15:0]       acc_data,
  output logic              reg_write_x,
  output logic              reg_write_y,
  output logic              reg_write_accumulator,
  output logic [15:0]       wr_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              done,
  output logic              err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("load_store_unit: TIMEOUT must be at least 1");
  end

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic              r_store;
  lsu_reg_e          r_reg;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_buf;

`ifdef LSU_TIMEOUT_EN
  logic w_expired;

  lsu_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (r_state != ST_MEM),
    .i_enable  (r_state == ST_MEM),
    .o_expired (w_expired)
  );
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; a stalled MEM access can only leave via mem_ack or the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (is_rsvd_reg(cmd_reg)) begin
            w_next = ST_ERROR;
          end else if (cmd_store) begin
            w_next = ST_CAPTURE;
          end else begin
            w_next = ST_MEM;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_CAPTURE: w_next = ST_MEM;
      ST_MEM: begin
        if (mem_ack) begin
          w_next = r_store ? ST_DONE : ST_WRITE;
`ifdef LSU_TIMEOUT_EN
        end else if (w_expired) begin
          w_next = ST_ERROR;
`endif
        end else begin
          w_next = ST_MEM;
        end
      end
      ST_WRITE: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      ST_ERROR: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Latched command and the data buffer shared by the store and load paths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_store <= 1'b0;
      r_reg   <= REG_X;
      r_addr  <= '0;
      r_buf   <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_store <= cmd_store;
            r_reg   <= lsu_reg_e'(cmd_reg);
            r_addr  <= cmd_addr;
            r_buf   <= 16'h0000;
          end
        end
        ST_CAPTURE: r_buf <= (r_reg == REG_ACC) ? acc_data : reg_data;
        ST_MEM: begin
          if (mem_ack && !r_store) begin
            r_buf <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore output decode; everything idles at zero outside its owning state.
  always_comb begin
    cmd_ready             = 1'b0;
    reg_read_x            = 1'b0;
    reg_read_y            = 1'b0;
    reg_write_x           = 1'b0;
    reg_write_y           = 1'b0;
    reg_write_accumulator = 1'b0;
    wr_data               = 16'h0000;
    mem_req               = 1'b0;
    mem_we                = 1'b0;
    mem_addr              = '0;
    mem_wdata             = 16'h0000;
    done                  = 1'b0;
    err                   = 1'b0;
    case (r_state)
      ST_IDLE: cmd_ready = !rst;
      ST_CAPTURE: begin
        reg_read_x = (r_reg == REG_X);
        reg_read_y = (r_reg == REG_Y);
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        mem_we    = r_store;
        mem_addr  = r_addr;
        mem_wdata = r_store ? r_buf : 16'h0000;
      end
      ST_WRITE: begin
        wr_data               = r_buf;
        reg_write_x           = (r_reg == REG_X);
        reg_write_y           = (r_reg == REG_Y);
        reg_write_accumulator = (r_reg == REG_ACC);
      end
      ST_DONE:  done = 1'b1;
      ST_ERROR: err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected command outcomes are queued at
// issue time and retired by a monitor when done/err pulses.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_store = 1'b0;
  logic [1:0]  cmd_reg = 2'b00;
  logic [9:0]  cmd_addr = 10'h000;
  logic        reg_read_x, reg_read_y;
  logic [15:0] reg_data, acc_data;
  logic        reg_write_x, reg_write_y, reg_write_accumulator;
  logic [15:0] wr_data;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        done, err;

  logic [15:0] rf_x = 16'hA5A5;
  logic [15:0] rf_y = 16'h5A5A;
  logic [15:0] rf_acc = 16'h0F0F;

  assign reg_data = reg_read_x ? rf_x : (reg_read_y ? rf_y : 16'h0000);
  assign acc_data = rf_acc;

  load_store_unit #(.ADDR_W(10), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
    .reg_read_x(reg_read_x), .reg_read_y(reg_read_y),
    .reg_data(reg_data), .acc_data(acc_data),
    .reg_write_x(reg_write_x), .reg_write_y(reg_write_y),
    .reg_write_accumulator(reg_write_accumulator), .wr_data(wr_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .done(done), .err(err)
  );

  typedef struct {
    logic        is_err;
    logic        is_store;
    logic        mem_used;
    logic [1:0]  sel;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t_acc = 0;
  logic [1:0]  mon_rd = 2'b00;
  logic        mon_mem = 1'b0;
  int          mon_wcnt = 0;
  logic [2:0]  mon_wsel = 3'b000;
  logic [15:0] mon_wdata = 16'h0000;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_read(input exp_t e);
    if (e.is_err || !e.is_store) return 2'b00;
    if (e.sel == 2'b00) return 2'b01;
    if (e.sel == 2'b01) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [2:0] exp_wsel(input logic [1:0] sel);
    if (sel == 2'b00) return 3'b001;
    if (sel == 2'b01) return 3'b010;
    return 3'b100;
  endfunction

  // Monitor: accumulates per-command activity and retires scoreboard entries.
  always @(negedge clk) begin
    if (rst) begin
      mon_rd = 2'b00; mon_mem = 1'b0; mon_wcnt = 0; mon_wsel = 3'b000; mon_wdata = 16'h0000;
    end else begin
      chk("read_onehot", 32'(reg_read_x & reg_read_y), 32'd0);
      chk("write_onehot", 32'($countones({reg_write_x, reg_write_y, reg_write_accumulator}) > 1), 32'd0);
      if (!(reg_write_x || reg_write_y || reg_write_accumulator))
        chk("wr_data_idle", 32'(wr_data), 32'd0);
      mon_rd = mon_rd | {reg_read_y, reg_read_x};
      mon_mem = mon_mem | mem_req;
      if (reg_write_x || reg_write_y || reg_write_accumulator) begin
        mon_wcnt++;
        mon_wsel = {reg_write_accumulator, reg_write_y, reg_write_x};
        mon_wdata = wr_data;
      end
      if (done || err) begin
        if (sb.size() == 0) begin
          chk("unexpected_end", 32'({done, err}), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("end_is_err", 32'(err), 32'(mon_e.is_err));
          chk("end_mem_used", 32'(mon_mem), 32'(mon_e.mem_used));
          chk("end_reads", 32'(mon_rd), 32'(exp_read(mon_e)));
          chk("end_write_count", 32'(mon_wcnt), (!mon_e.is_err && !mon_e.is_store) ? 32'd1 : 32'd0);
          if (!mon_e.is_err && !mon_e.is_store) begin
            chk("end_write_sel", 32'(mon_wsel), 32'(exp_wsel(mon_e.sel)));
            chk("end_write_data", 32'(mon_wdata), 32'(mon_e.data));
          end
        end
        mon_rd = 2'b00; mon_mem = 1'b0; mon_wcnt = 0; mon_wsel = 3'b000; mon_wdata = 16'h0000;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({cmd_ready, reg_read_x, reg_read_y, reg_write_x, reg_write_y,
                             reg_write_accumulator, mem_req, mem_we, done, err}), 32'd0);
    chk({tag, "_data"}, {wr_data, mem_wdata}, 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
  endtask

  task automatic issue(input logic st, input logic [1:0] rg, input logic [9:0] ad, input logic keep);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_store = st; cmd_reg = rg; cmd_addr = ad;
    chk("ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    t_acc = cyc;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_mem(input logic st, input logic [9:0] ad, input logic [15:0] wd,
                          input int waits, input logic [15:0] rd);
    int k;
    k = 0;
    @(negedge clk);
    while (!mem_req && k < 50) begin @(negedge clk); k++; end
    chk("mem_req_seen", 32'(mem_req), 32'd1);
    chk("mem_we", 32'(mem_we), 32'(st));
    chk("mem_addr", 32'(mem_addr), 32'(ad));
    chk("mem_wdata", 32'(mem_wdata), st ? 32'(wd) : 32'd0);
    repeat (waits) @(negedge clk);
    chk("mem_hold", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = rd;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
  endtask

  task automatic wait_end(input string tag, input int lat);
    int k;
    k = 0;
    @(negedge clk);
    while (!(done || err) && k < 300) begin @(negedge clk); k++; end
    chk({tag, "_end_seen"}, 32'(done | err), 32'd1);
    chk({tag, "_latency"}, cyc - t_acc + 1, lat);
    chk({tag, "_ready_busy"}, 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_single_pulse"}, 32'({done, err}), 32'd0);
    chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int mcount;
    int k;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    #1 chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Store X, immediate ack.
    sb.push_back('{1'b0, 1'b1, 1'b1, 2'b00, 16'hA5A5});
    issue(1'b1, 2'b00, 10'h012, 1'b0);
    wait_mem(1'b1, 10'h012, 16'hA5A5, 0, 16'h0000);
    wait_end("store_x", 3);

    // Load accumulator, four wait cycles.
    sb.push_back('{1'b0, 1'b0, 1'b1, 2'b10, 16'h1234});
    issue(1'b0, 2'b10, 10'h3FF, 1'b0);
    wait_mem(1'b0, 10'h3FF, 16'h0000, 4, 16'h1234);
    wait_end("load_acc", 7);

    // Reserved register select.
    sb.push_back('{1'b1, 1'b1, 1'b0, 2'b11, 16'h0000});
    issue(1'b1, 2'b11, 10'h001, 1'b0);
    wait_end("reserved", 1);

    // Store accumulator (no read select) and load X with one wait cycle.
    sb.push_back('{1'b0, 1'b1, 1'b1, 2'b10, 16'h0F0F});
    issue(1'b1, 2'b10, 10'h0AA, 1'b0);
    wait_mem(1'b1, 10'h0AA, 16'h0F0F, 0, 16'h0000);
    wait_end("store_acc", 3);
    sb.push_back('{1'b0, 1'b0, 1'b1, 2'b00, 16'hC3C3});
    issue(1'b0, 2'b00, 10'h200, 1'b0);
    wait_mem(1'b0, 10'h200, 16'h0000, 1, 16'hC3C3);
    wait_end("load_x", 4);

    // Reset while a load of Y sits in MEM.
    issue(1'b0, 2'b01, 10'h155, 1'b0);
    k = 0;
    @(negedge clk);
    while (!mem_req && k < 20) begin @(negedge clk); k++; end
    chk("abort_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1 check_all_zero("abort");
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_ready", 32'(cmd_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("abort_quiet", 32'({mem_req, done, err, reg_write_y}), 32'd0);
    end
    sb.push_back('{1'b0, 1'b1, 1'b1, 2'b01, 16'h5A5A});
    issue(1'b1, 2'b01, 10'h156, 1'b0);
    wait_mem(1'b1, 10'h156, 16'h5A5A, 0, 16'h0000);
    wait_end("store_y", 3);

    // Memory never acknowledges.
    mcount = 0;
`ifdef LSU_TIMEOUT_EN
    sb.push_back('{1'b1, 1'b0, 1'b1, 2'b00, 16'h0000});
    issue(1'b0, 2'b00, 10'h0F0, 1'b0);
    k = 0;
    @(negedge clk);
    while (!err && k < 60) begin
      if (mem_req) mcount++;
      @(negedge clk);
      k++;
    end
    chk("timeout_mem_cycles", mcount, 32'd15);
    chk("timeout_err", 32'(err), 32'd1);
    @(negedge clk);
    chk("timeout_ready_back", 32'(cmd_ready), 32'd1);
`else
    sb.push_back('{1'b0, 1'b0, 1'b1, 2'b00, 16'hBEEF});
    issue(1'b0, 2'b00, 10'h0F0, 1'b0);
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (mem_req) mcount++;
    end
    chk("no_timeout_mem_cycles", mcount, 32'd110);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    wait_end("no_timeout", 112);
`endif

    // Stray ack in IDLE, then two commands with cmd_valid held high.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    chk("stray_ack_ready", 32'(cmd_ready), 32'd1);
    chk("stray_ack_quiet", 32'({mem_req, done, err, reg_write_x, reg_write_y, reg_write_accumulator}), 32'd0);
    sb.push_back('{1'b0, 1'b1, 1'b1, 2'b00, 16'hA5A5});
    sb.push_back('{1'b0, 1'b0, 1'b1, 2'b01, 16'h7E7E});
    issue(1'b1, 2'b00, 10'h055, 1'b1);
    cmd_store = 1'b0; cmd_reg = 2'b01; cmd_addr = 10'h066;
    @(negedge clk);
    chk("b2b_busy_ready", 32'(cmd_ready), 32'd0);
    wait_mem(1'b1, 10'h055, 16'hA5A5, 0, 16'h0000);
    wait_end("b2b_first", 3);
    @(posedge clk); #1;
    t_acc = cyc;
    cmd_valid = 1'b0;
    wait_mem(1'b0, 10'h066, 16'h0000, 2, 16'h7E7E);
    wait_end("b2b_second", 5);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, 10, memory address width.
REQ-002 Parameter: TIMEOUT, 15, max MEM-state cycles awaiting mem_ack (used only with LSU_TIMEOUT_EN).
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: cmd_valid  in  1 / cmd_ready  out  1  command handshake, accept when both high on a clock edge.
REQ-006 Port: cmd_store  in  1  1 = register->memory, 0 = memory->register.
REQ-007 Port: cmd_reg  in  2  00 X, 01 Y, 10 accumulator, 11 reserved.
REQ-008 Port: cmd_addr  in  ADDR_W  memory address.
REQ-009 Port: reg_read_x, reg_read_y  out  1 each  register-file read selects.
REQ-010 Port: reg_data  in  16 (X/Y read data); acc_data  in  16 (accumulator read data).
REQ-011 Port: reg_write_x, reg_write_y, reg_write_accumulator  out  1 each; wr_data  out  16  register-file write bus.
REQ-012 Port: mem_req, mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  16; mem_ack  in  1; mem_rdata  in  16.
REQ-013 Port: done  out  1, err  out  1  one-cycle completion / error pulses.

Function
REQ-014 FSM states: IDLE, CAPTURE, MEM, WRITE, DONE, ERROR; all outputs Moore-decoded from state plus latched command.
REQ-015 IDLE: cmd_ready=1; on accept latch cmd_store, cmd_reg, cmd_addr; cmd_reg=11 -> ERROR; store -> CAPTURE; load -> MEM.
REQ-016 CAPTURE (one cycle): assert reg_read_x or reg_read_y per latched reg (none for accumulator); latch reg_data or acc_data into 16-bit buffer; -> MEM.
REQ-017 MEM: mem_req=1, mem_we=latched store, mem_addr=latched addr, mem_wdata=buffer (0 on load); hold until mem_ack sampled high.
REQ-018 MEM + mem_ack: store -> DONE; load -> latch mem_rdata into buffer, -> WRITE.
REQ-019 WRITE (one cycle): wr_data=buffer, exactly one of reg_write_x/y/accumulator high per latched reg; -> DONE.
REQ-020 DONE: done=1 for one cycle; -> IDLE. ERROR: err=1 for one cycle, no register/memory activity; -> IDLE.
REQ-021 Latency with mem_ack in first MEM cycle: done high 3 cycles after accept edge for both load and store.
REQ-022 cmd_ready=0 in every non-IDLE state; cmd_valid outside IDLE ignored, no queuing.
REQ-023 mem_ack outside MEM ignored; never more than one reg_write_* or reg_read_* high in any cycle.
REQ-024 wr_data=0 and all select/strobe outputs 0 outside their owning state.

Reset
REQ-025 rst high: state=IDLE, buffer and latched command cleared, every output 0 (cmd_ready forced 0 while rst high).
REQ-026 rst asserted mid-operation aborts immediately: no done, err, write or mem_req pulse produced for aborted command.
REQ-027 After rst deassert: cmd_ready=1 from first cycle.

Configuration
REQ-028 Macro LSU_TIMEOUT_EN defined: cycle counter runs in MEM; if mem_ack not seen within TIMEOUT cycles -> ERROR (err pulse), no register write.
REQ-029 Macro LSU_TIMEOUT_EN undefined: no counter logic; MEM waits for mem_ack indefinitely.

Structure
REQ-030 Shared package lsu_pkg holds state enum, cmd_reg encodings (REG_X, REG_Y, REG_ACC, REG_RSVD), default ADDR_W.
REQ-031 One sub-module lsu_timeout_counter (clear/enable/expired), instantiated only under LSU_TIMEOUT_EN.

Verification
REQ-032 Store X: X read=16'hA5A5, cmd store/reg 00/addr 10'h012, mem_ack immediate -> reg_read_x in CAPTURE, mem_we=1, mem_wdata=A5A5, mem_addr=012, done at accept+3.
REQ-033 Load ACC: cmd load/reg 10/addr 10'h3FF, mem_ack after 4 wait cycles, mem_rdata=16'h1234 -> one-cycle reg_write_accumulator, wr_data=1234, done at accept+7.
REQ-034 Reserved reg: cmd_reg=11 -> err pulse next cycle, mem_req, reg_read_*, reg_write_* never high, cmd_ready back next cycle.
REQ-035 Reset mid-MEM: load of Y, rst pulsed while mem_req=1 -> all outputs 0, no reg_write_y, no done; following store of Y=16'h5A5A completes normally.
REQ-036 Timeout (LSU_TIMEOUT_EN, TIMEOUT=15): mem_ack never asserted -> err after 15 MEM cycles, no write; without macro mem_req stays high 100+ cycles.
REQ-037 Back-to-back: cmd_valid held high for two commands -> second accepted only in IDLE after first done, stray mem_ack in IDLE ignored.
